// File: rtl/fifo_param_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param_buffer
// Description : Synchronous single-clock FIFO with registered read data,
//               occupancy count, almost-full/empty thresholds and sticky
//               overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    EN,
    input  logic                    CLR,
    input  logic                    WR,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    input  logic                    RD,
    output logic [DATA_WIDTH-1:0]   dataOut,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    ALMOST_EMPTY,
    output logic                    ALMOST_FULL,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;

    // Status flags come straight off the count register, no extra pipeline.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_W'(DEPTH));

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_rd_ok = EN & RD & ~w_empty & ~CLR;
    assign w_wr_ok = EN & WR & ~CLR & (~w_full | w_rd_ok);

    assign EMPTY        = w_empty;
    assign FULL         = w_full;
    assign ALMOST_EMPTY = (r_count <= c_CNT_W'(AE_LEVEL));
    assign ALMOST_FULL  = (r_count >= c_CNT_W'(AF_LEVEL));
    assign COUNT        = r_count;
    assign dataOut      = r_data_out;
    assign OVERFLOW     = r_overflow;
    assign UNDERFLOW    = r_underflow;

    // Storage is deliberately not reset; the zeroed count hides stale entries.
    always_ff @(posedge Clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (EN) begin
            if (CLR) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_data_out  <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
                end
                if (w_rd_ok) begin
                    r_data_out <= r_mem[r_rd_ptr];
                    r_rd_ptr   <= r_rd_ptr + c_ADDR_W'(1);
                end
                case ({w_wr_ok, w_rd_ok})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
                if (WR && !w_wr_ok) begin
                    r_overflow <= 1'b1;
                end
                if (RD && w_empty) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_param_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_param_buffer
// Description : Directed and randomized checks of fifo_param_buffer against a
//               queue-based reference model (DEPTH=8, AF=6, AE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param_buffer;

    localparam int c_DW    = 32;
    localparam int c_DEPTH = 8;

    logic            Clk;
    logic            Rst;
    logic            EN;
    logic            CLR;
    logic            WR;
    logic            RD;
    logic [c_DW-1:0] dataIn;
    logic [c_DW-1:0] dataOut;
    logic            EMPTY;
    logic            FULL;
    logic            ALMOST_EMPTY;
    logic            ALMOST_FULL;
    logic [3:0]      COUNT;
    logic            OVERFLOW;
    logic            UNDERFLOW;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: contents as a queue plus the sticky flags and output word.
    logic [c_DW-1:0] q[$];
    logic [c_DW-1:0] m_dout;
    logic            m_ovf;
    logic            m_unf;

    logic [41:0] w_dut_vec;
    assign w_dut_vec = {COUNT, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
                        OVERFLOW, UNDERFLOW, dataOut};

    fifo_param_buffer #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .EN           (EN),
        .CLR          (CLR),
        .WR           (WR),
        .dataIn       (dataIn),
        .RD           (RD),
        .dataOut      (dataOut),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [41:0] exp_vec();
        int n;
        n = q.size();
        return {4'(n), n == 0, n == c_DEPTH, n <= 2, n >= 6, m_ovf, m_unf, m_dout};
    endfunction

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic clr, input logic wr,
                              input logic rd, input logic [c_DW-1:0] din);
        bit rd_acc;
        bit wr_acc;
        if (!en) return;
        if (clr) begin
            model_reset();
            return;
        end
        rd_acc = rd && (q.size() > 0);
        wr_acc = wr && ((q.size() < c_DEPTH) || rd_acc);
        if (rd && q.size() == 0) m_unf = 1'b1;
        if (wr && !wr_acc)       m_ovf = 1'b1;
        if (rd_acc) m_dout = q.pop_front();
        if (wr_acc) q.push_back(din);
    endtask

    // Apply one cycle of inputs, advance to just after the edge, update the model.
    task automatic cycle(input logic en, input logic clr, input logic wr,
                         input logic rd, input logic [c_DW-1:0] din);
        EN = en; CLR = clr; WR = wr; RD = rd; dataIn = din;
        @(posedge Clk);
        #1;
        model_step(en, clr, wr, rd, din);
    endtask

    task automatic test_reset();
        Rst = 1'b1; EN = 1'b0; CLR = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
        #2 Rst = 1'b0;
        model_reset();
        #2;
        n_cmp++;
        if ({COUNT, EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW, dataOut}
            !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b d=%h, want 0 1 1 0 0 0 0 0",
                     COUNT, EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW, dataOut);
        end
        @(negedge Clk) Rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 0, 1, 0, 32'(i));
            n_cmp++;
            if ({COUNT, ALMOST_EMPTY, ALMOST_FULL, FULL} !== {4'(i), i <= 2, i >= 6, i == 8}) begin
                n_fail++;
                $display("FAIL fill_%0d: got cnt=%0d ae=%b af=%b f=%b, want cnt=%0d ae=%b af=%b f=%b",
                         i, COUNT, ALMOST_EMPTY, ALMOST_FULL, FULL, i, i <= 2, i >= 6, i == 8);
            end
        end
        cycle(1, 0, 1, 0, 32'd9);
        n_cmp++;
        if ({OVERFLOW, COUNT} !== {1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL fill_overflow: got ov=%b cnt=%0d, want ov=1 cnt=8", OVERFLOW, COUNT);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 0, 0, 1, '0);
            n_cmp++;
            if (dataOut !== 32'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: got dataOut=%h, want %h", i, dataOut, 32'(i));
            end
        end
        n_cmp++;
        if ({EMPTY, UNDERFLOW} !== 2'b10) begin
            n_fail++;
            $display("FAIL drain_empty: got e=%b un=%b, want e=1 un=0", EMPTY, UNDERFLOW);
        end
        cycle(1, 0, 0, 1, '0);
        n_cmp++;
        if ({UNDERFLOW, dataOut} !== {1'b1, 32'd8}) begin
            n_fail++;
            $display("FAIL drain_underflow: got un=%b d=%h, want un=1 d=8", UNDERFLOW, dataOut);
        end
    endtask

    task automatic test_simul_full();
        cycle(1, 1, 0, 0, '0);
        for (int i = 1; i <= 8; i++) cycle(1, 0, 1, 0, 32'(i));
        cycle(1, 0, 1, 1, 32'hA5);
        n_cmp++;
        if ({COUNT, dataOut, OVERFLOW} !== {4'd8, 32'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL full_rw: got cnt=%0d d=%h ov=%b, want cnt=8 d=1 ov=0", COUNT, dataOut, OVERFLOW);
        end
        for (int i = 2; i <= 8; i++) begin
            cycle(1, 0, 0, 1, '0);
            n_cmp++;
            if (dataOut !== 32'(i)) begin
                n_fail++;
                $display("FAIL wrap_%0d: got dataOut=%h, want %h", i, dataOut, 32'(i));
            end
        end
        cycle(1, 0, 0, 1, '0);
        n_cmp++;
        if ({dataOut, EMPTY} !== {32'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_a5: got d=%h e=%b, want d=a5 e=1", dataOut, EMPTY);
        end
    endtask

    task automatic test_clear_and_disable();
        cycle(1, 0, 1, 0, 32'h11);
        cycle(1, 0, 1, 0, 32'h22);
        cycle(1, 0, 1, 0, 32'h33);
        cycle(1, 0, 0, 1, '0);
        cycle(1, 0, 0, 1, '0);
        cycle(1, 0, 0, 1, '0);
        cycle(1, 0, 0, 1, '0);
        cycle(1, 0, 1, 0, 32'h44);
        cycle(1, 0, 1, 0, 32'h45);
        cycle(1, 0, 1, 0, 32'h46);
        cycle(1, 1, 1, 0, 32'h99);
        n_cmp++;
        if ({COUNT, EMPTY, OVERFLOW, UNDERFLOW, dataOut} !== {4'd0, 1'b1, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL clear: got cnt=%0d e=%b ov=%b un=%b d=%h, want 0 1 0 0 0",
                     COUNT, EMPTY, OVERFLOW, UNDERFLOW, dataOut);
        end
        cycle(1, 0, 1, 0, 32'h55);
        cycle(1, 0, 1, 0, 32'h66);
        cycle(1, 0, 0, 1, '0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            n_cmp++;
            if ({COUNT, dataOut, OVERFLOW, UNDERFLOW} !== {4'd1, 32'h55, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL disabled_%0d: got cnt=%0d d=%h ov=%b un=%b, want 1 55 0 0",
                         i, COUNT, dataOut, OVERFLOW, UNDERFLOW);
            end
        end
        cycle(1, 0, 0, 1, '0);
        n_cmp++;
        if (dataOut !== 32'h66) begin
            n_fail++;
            $display("FAIL disabled_mem: got dataOut=%h, want 66", dataOut);
        end
    endtask

    task automatic test_empty_rw();
        cycle(1, 0, 1, 1, 32'hBEEF);
        n_cmp++;
        if ({COUNT, UNDERFLOW, dataOut} !== {4'd1, 1'b1, 32'h66}) begin
            n_fail++;
            $display("FAIL empty_rw: got cnt=%0d un=%b d=%h, want 1 1 66", COUNT, UNDERFLOW, dataOut);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 32'h100 + 32'(i));
        cycle(1, 0, 0, 1, '0);
        EN = 1'b1; WR = 1'b1; dataIn = 32'hDEAD;
        #3 Rst = 1'b0;
        #1;
        n_cmp++;
        if ({COUNT, EMPTY, ALMOST_EMPTY, dataOut} !== {4'd0, 1'b1, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d e=%b ae=%b d=%h, want 0 1 1 0",
                     COUNT, EMPTY, ALMOST_EMPTY, dataOut);
        end
        WR = 1'b0;
        #2 Rst = 1'b1;
        model_reset();
        cycle(1, 0, 0, 1, '0);
        n_cmp++;
        if ({UNDERFLOW, dataOut, COUNT} !== {1'b1, 32'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL stale_read: got un=%b d=%h cnt=%0d, want 1 0 0", UNDERFLOW, dataOut, COUNT);
        end
        cycle(1, 0, 1, 0, 32'h77);
        cycle(1, 0, 0, 1, '0);
        n_cmp++;
        if (dataOut !== 32'h77) begin
            n_fail++;
            $display("FAIL post_reset: got dataOut=%h, want 77", dataOut);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom);
            n_cmp++;
            if (w_dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got {cnt,e,f,ae,af,ov,un,d}=%h, want %h",
                         i, w_dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simul_full();
        test_clear_and_disable();
        test_empty_rw();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_param_buffer.md
FIFO_PARAM_BUFFER -- requirements
Module: fifo_param_buffer

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, width of dataIn/dataOut.
REQ-002 SHALL provide parameter DEPTH, default 16, number of entries; a power of 2 and >= 2.
REQ-003 SHALL provide parameter AF_LEVEL, default DEPTH-2, ALMOST_FULL threshold in entries.
REQ-004 SHALL provide parameter AE_LEVEL, default 2, ALMOST_EMPTY threshold in entries; AE_LEVEL < AF_LEVEL <= DEPTH.
REQ-005 SHALL use CW = $clog2(DEPTH)+1 as the COUNT width.
REQ-006 Clk  input  1  single clock; all state changes on the rising edge.
REQ-007 Rst  input  1  asynchronous, active-low reset.
REQ-008 EN  input  1  global enable; when 0, RD, WR and CLR are ignored.
REQ-009 CLR  input  1  synchronous flush (qualified by EN).
REQ-010 WR  input  1  write request.
REQ-011 dataIn  input  DATA_WIDTH  write data.
REQ-012 RD  input  1  read request.
REQ-013 dataOut  output  DATA_WIDTH  registered read data.
REQ-014 EMPTY, FULL  output  1 each  occupancy == 0 / occupancy == DEPTH.
REQ-015 ALMOST_EMPTY, ALMOST_FULL  output  1 each  COUNT <= AE_LEVEL / COUNT >= AF_LEVEL.
REQ-016 COUNT  output  CW  current occupancy, 0..DEPTH.
REQ-017 OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-018 rd_ok SHALL equal EN & RD & !EMPTY & !CLR.
REQ-019 wr_ok SHALL equal EN & WR & !CLR & (!FULL | rd_ok); a write to a full FIFO is accepted only with a simultaneous accepted read.
REQ-020 On wr_ok, dataIn SHALL be stored at wr_ptr, and wr_ptr SHALL advance by 1, wrapping from DEPTH-1 to 0.
REQ-021 On rd_ok, dataOut SHALL load the entry at rd_ptr at that edge (1-cycle read latency), and rd_ptr SHALL advance with the same wrap rule.
REQ-022 Without rd_ok, dataOut SHALL hold its value.
REQ-023 COUNT SHALL increment on wr_ok only, decrement on rd_ok only, and stay unchanged when both or neither occur.
REQ-024 EMPTY, FULL, ALMOST_* SHALL be decoded combinationally from the COUNT register, with no added latency beyond COUNT.
REQ-025 OVERFLOW SHALL set when EN & WR & !CLR & !wr_ok, and UNDERFLOW SHALL set when EN & RD & !CLR & EMPTY.
REQ-026 OVERFLOW and UNDERFLOW SHALL remain set until CLR or reset.
REQ-027 A rejected request SHALL NOT change the pointers, COUNT, memory or dataOut.
REQ-028 Read and write on an empty FIFO in the same cycle: the write SHALL be accepted, the read rejected (UNDERFLOW set), and COUNT SHALL become 1.
REQ-029 When EN=1 and CLR=1, the next edge SHALL zero the pointers, COUNT, OVERFLOW, UNDERFLOW and dataOut; CLR SHALL take priority over RD/WR in that cycle.
REQ-030 When EN=0, all registers SHALL hold.
REQ-031 Data SHALL emerge in write order (FIFO ordering), including across pointer wrap.

Reset
REQ-032 Rst=0 SHALL immediately, independent of Clk, clear wr_ptr, rd_ptr, COUNT, dataOut, OVERFLOW and UNDERFLOW.
REQ-033 Reset values SHALL be EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0.
REQ-034 Memory contents SHALL NOT be reset, and no stale entry SHALL be readable after reset.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer; operation SHALL resume on the first rising edge after Rst returns to 1.

Verification (DATA_WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-036 Reset, then write 1..8 with EN=1 -> COUNT 1..8; ALMOST_EMPTY drops at COUNT=3; ALMOST_FULL rises at COUNT=6; FULL=1 at COUNT=8; ninth write of 9 -> OVERFLOW=1, COUNT=8.
REQ-037 Read 8 times -> dataOut 1..8, each one cycle after its read; EMPTY=1; ninth read -> UNDERFLOW=1, dataOut holds 8.
REQ-038 Fill to 8, then RD=WR=1 with dataIn=0xA5 -> COUNT stays 8, dataOut=1, no OVERFLOW; continue reads -> 0xA5 appears after 2..8 (wrap verified).
REQ-039 Write 3 words, pulse CLR with WR=1 -> COUNT=0, EMPTY=1, flags 0, dataOut=0, write dropped; EN=0 with RD/WR/CLR toggling -> no state change.
REQ-040 Write 5 words, assert Rst=0 between edges -> outputs reset asynchronously; after release, a write of 0x77 then a read -> dataOut=0x77.
